ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_pkg.sv | 47 ++++
 rtl/ex_stage_div.sv | 76 +++++++
 rtl/ex_stage.sv | 132 +++++++++++++
 tb/tb_ex_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared EX-stage definitions: bus widths, stall encoding, decode constants.
// The optional EX_DIV_EN divider uses the state type and magnitude helper here.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_RF_WD  = 38;
  localparam int STALL_BUS    = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_t;

  function automatic logic [31:0] mag(input logic [31:0] v,
                                      input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// div_unit: 32-step restoring divider on magnitudes, signs fixed up at the end.
// Divide by zero yields all-ones quotient and the dividend as remainder.
module div_unit
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_t  st;
  logic [4:0]  cnt;
  logic [31:0] q, r, d, a;
  logic        neg_q, neg_r, dz;
  logic [32:0] shifted, trial;

  assign shifted = {r, q[31]};
  assign trial   = shifted - {1'b0, d};

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= DIV_IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      a     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else begin
      unique case (st)
        DIV_IDLE: begin
          ready <= 1'b0;
          if (start) begin
            st    <= DIV_RUN;
            cnt   <= '0;
            q     <= mag(opa, signed_op);
            r     <= '0;
            d     <= mag(opb, signed_op);
            a     <= opa;
            neg_q <= signed_op & (opa[31] ^ opb[31]);
            neg_r <= signed_op & opa[31];
            dz    <= (opb == '0);
          end
        end
        DIV_RUN: begin
          // borrow out of the trial subtract means the bit is 0
          q   <= {q[30:0], ~trial[32]};
          r   <= trial[32] ? shifted[31:0] : trial[31:0];
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            st    <= DIV_DONE;
            ready <= 1'b1;
          end
        end
        DIV_DONE: begin
          st    <= DIV_IDLE;
          ready <= 1'b0;
        end
        default: st <= DIV_IDLE;
      endcase
    end
  end

  assign quotient  = dz ? '1 : (neg_q ? -q : q);
  assign remainder = dz ? a : (neg_r ? -r : r);

endmodule

// File: rtl/ex_stage.sv
// EX pipeline stage: ALU, data SRAM request, hi/lo, optional divider.
// Define EX_DIV_EN to build the div_unit; otherwise div/divu are no-ops.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    ex_is_load,
  output logic                    stallreq_for_ex
);

  id_ex_t r;

  always_ff @(posedge clk) begin
    if (rst) r <= '0;
    else if (stall[2] == STOP && stall[3] == NO_STOP) r <= '0;
    else if (stall[2] == NO_STOP) r <= id_ex_t'(id_to_ex_bus);
  end

  logic        spec_op, is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic [5:0]  fn;
  logic [31:0] src1, src2, alu_res, ex_result, hi, lo;
  logic [31:0] imm_s, imm_z, quo, rem;
  logic        div_ready;

  assign spec_op = (r.inst[31:26] == OP_SPECIAL);
  assign fn      = r.inst[5:0];
  assign is_mfhi = spec_op && fn == FN_MFHI;
  assign is_mflo = spec_op && fn == FN_MFLO;
  assign is_mthi = spec_op && fn == FN_MTHI;
  assign is_mtlo = spec_op && fn == FN_MTLO;

  assign imm_s = {{16{r.inst[15]}}, r.inst[15:0]};
  assign imm_z = {16'd0, r.inst[15:0]};

  assign src1 = ({32{r.sel_alu_src1[0]}} & r.rdata1)
              | ({32{r.sel_alu_src1[1]}} & r.pc)
              | ({32{r.sel_alu_src1[2]}} & {27'd0, r.inst[10:6]});
  assign src2 = ({32{r.sel_alu_src2[0]}} & r.rdata2)
              | ({32{r.sel_alu_src2[1]}} & imm_s)
              | ({32{r.sel_alu_src2[2]}} & 32'd8)
              | ({32{r.sel_alu_src2[3]}} & imm_z);

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      r.alu_op[11]: alu_res = src1 + src2;
      r.alu_op[10]: alu_res = src1 - src2;
      r.alu_op[9]:  alu_res = {31'd0, $signed(src1) < $signed(src2)};
      r.alu_op[8]:  alu_res = {31'd0, src1 < src2};
      r.alu_op[7]:  alu_res = src1 & src2;
      r.alu_op[6]:  alu_res = ~(src1 | src2);
      r.alu_op[5]:  alu_res = src1 | src2;
      r.alu_op[4]:  alu_res = src1 ^ src2;
      r.alu_op[3]:  alu_res = src2 << src1[4:0];
      r.alu_op[2]:  alu_res = src2 >> src1[4:0];
      r.alu_op[1]:  alu_res = $signed(src2) >>> src1[4:0];
      r.alu_op[0]:  alu_res = {src2[15:0], 16'd0};
      default:      alu_res = '0;
    endcase
  end

  assign ex_result = is_mfhi ? hi : (is_mflo ? lo : alu_res);

  assign ex_to_mem_bus = {r.pc, r.data_ram_en, r.data_ram_wen,
                          r.sel_rf_res, r.rf_we, r.rf_waddr,
                          ex_result};
  assign ex_to_rf_bus  = {r.rf_we, r.rf_waddr, ex_result};

  assign data_sram_en    = r.data_ram_en;
  assign data_sram_wen   = r.data_ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = r.rdata2;
  assign ex_is_load      = r.data_ram_en & ~|r.data_ram_wen & r.rf_we;

`ifdef EX_DIV_EN
  logic is_div, div_done, div_start, reload;

  assign is_div    = spec_op && (fn == FN_DIV || fn == FN_DIVU);
  assign reload    = !(stall[2] == STOP && stall[3] == STOP);
  assign div_start = is_div && !div_done;
  assign stallreq_for_ex = div_start && !div_ready;

  // blocks a second run of the same div until EX takes a new instruction
  always_ff @(posedge clk) begin
    if (rst || reload) div_done <= 1'b0;
    else if (div_ready) div_done <= 1'b1;
  end

  div_unit u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (fn == FN_DIV),
    .opa       (r.rdata1),
    .opb       (r.rdata2),
    .ready     (div_ready),
    .quotient  (quo),
    .remainder (rem)
  );
`else
  assign div_ready       = 1'b0;
  assign quo             = '0;
  assign rem             = '0;
  assign stallreq_for_ex = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_ready) begin
      hi <= rem;
      lo <= quo;
    end else if (stall[3] == NO_STOP) begin
      if (is_mthi) hi <= r.rdata1;
      if (is_mtlo) lo <= r.rdata1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{r.inst[25:16], stall[5:4], stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus random ALU traffic.
// Division cases run only when EX_DIV_EN is defined for the build.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   tb_stall;
  logic [5:0]   stall;
  logic [158:0] id_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         ex_is_load;
  logic         stallreq_for_ex;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m, lo_m;

  always #5 clk = ~clk;

  // a divider stall request freezes IF/ID/EX as the hazard unit would
  assign stall = stallreq_for_ex ? 6'b001111 : tb_stall;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .ex_is_load      (ex_is_load),
    .stallreq_for_ex (stallreq_for_ex)
  );

  function automatic logic [158:0] mk(
    input logic [31:0] pc, input logic [31:0] inst,
    input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
    input logic en, input logic [3:0] wen, input logic we,
    input logic [4:0] wa, input logic sel,
    input logic [31:0] a, input logic [31:0] b);
    return {pc, inst, op, s1, s2, en, wen, we, wa, sel, a, b};
  endfunction

  function automatic logic [31:0] ref_alu(input int k,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (k)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return b << a[4:0];
      9:  return b >> a[4:0];
      10: return $signed(b) >>> a[4:0];
      11: return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [75:0] obs,
                     input logic [75:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [158:0] b);
    id_bus   = b;
    tb_stall = 6'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_alu(input string tag, input logic [31:0] pc,
                           input logic en, input logic [3:0] wen,
                           input logic sel, input logic we,
                           input logic [4:0] wa, input logic [31:0] wd,
                           input logic [31:0] res);
    chk({tag, "_mem"}, ex_to_mem_bus, {pc, en, wen, sel, we, wa, res});
    chk({tag, "_rf"}, ex_to_rf_bus, {we, wa, res});
    chk({tag, "_sram"},
        {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
        {en, wen, res, wd});
    chk({tag, "_load"}, ex_is_load, en && wen == 4'h0 && we);
  endtask

  function automatic logic [158:0] mf(input logic [5:0] fn,
                                      input logic [4:0] wa);
    return mk(32'h0, {6'h0, 10'h0, wa, 5'h0, fn}, 12'h0, 3'h0, 4'h0,
              1'b0, 4'h0, 1'b1, wa, 1'b0, 32'h0, 32'h0);
  endfunction

  function automatic logic [158:0] mt(input logic [5:0] fn,
                                      input logic [31:0] v);
    return mk(32'h0, {6'h0, 5'd3, 15'h0, fn}, 12'h0, 3'h0, 4'h0,
              1'b0, 4'h0, 1'b0, 5'h0, 1'b0, v, 32'h0);
  endfunction

`ifdef EX_DIV_EN
  task automatic run_div(input string tag, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int n;
    if (b == 32'h0) begin
      lo_m = 32'hFFFF_FFFF;
      hi_m = a;
    end else if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      lo_m = 32'(sa / sb);
      hi_m = 32'(sa % sb);
    end else begin
      lo_m = a / b;
      hi_m = a % b;
    end
    load(mk(32'h0, {6'h0, 5'd4, 5'd5, 10'h0, sgn ? FN_DIV : FN_DIVU},
            12'h0, 3'h0, 4'h0, 1'b0, 4'h0, 1'b0, 5'h0, 1'b0, a, b));
    id_bus = mf(FN_MFLO, 5'd9);
    n = 0;
    while (stallreq_for_ex === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk({tag, "_lat"}, n, 33);
    @(posedge clk);
    #1;
    chk({tag, "_lo"}, ex_to_rf_bus, {1'b1, 5'd9, lo_m});
    load(mf(FN_MFHI, 5'd10));
    chk({tag, "_hi"}, ex_to_rf_bus, {1'b1, 5'd10, hi_m});
  endtask
`endif

  initial begin
    int k, i1, i2;
    logic [31:0] pc, inst, a, b, x, y, res;
    logic [11:0] opv;
    logic en, we, sel;
    logic [3:0] wen;
    logic [4:0] wa;

    rst = 1'b1;
    tb_stall = 6'b0;
    id_bus = mk(32'h1234, 32'h2411_0005, 12'h800, 3'b001, 4'b0010,
                1'b1, 4'h0, 1'b1, 5'd3, 1'b1, 32'h55, 32'h66);
    @(posedge clk);
    #1;
    chk("rst_mem", ex_to_mem_bus, 76'h0);
    chk("rst_rf", ex_to_rf_bus, 38'h0);
    chk("rst_sram",
        {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 0);
    chk("rst_load", ex_is_load, 1'b0);
    chk("rst_stallreq", stallreq_for_ex, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hi_m = 32'h0;
    lo_m = 32'h0;

    // addiu r7, r1, -1 with r1 = 5
    load(mk(32'hBFC0_0000, {6'h09, 5'd1, 5'd7, 16'hFFFF}, 12'h800,
            3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd7, 1'b0,
            32'd5, 32'd0));
    check_alu("addiu", 32'hBFC0_0000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7,
              32'd0, 32'd4);

    load(mk(32'hBFC0_0004, {6'h2B, 5'd2, 5'd3, 16'd8}, 12'h800,
            3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0,
            32'h100, 32'hAB));
    check_alu("sw", 32'hBFC0_0004, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0,
              32'hAB, 32'h108);

    load(mk(32'hBFC0_0008, {6'h23, 5'd2, 5'd4, 16'd4}, 12'h800,
            3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd4, 1'b1,
            32'h200, 32'h0));
    check_alu("lw", 32'hBFC0_0008, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4,
              32'h0, 32'h204);

    // hold with ID and EX stopped, then a bubble with only ID stopped
    load(mk(32'h40, 32'h0062_1021, 12'h800, 3'b001, 4'b0001,
            1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd3, 32'd4));
    id_bus = mk(32'h44, 32'h0, 12'h400, 3'b001, 4'b0001,
                1'b1, 4'h3, 1'b1, 5'd9, 1'b1, 32'd9, 32'd1);
    tb_stall = 6'b001111;
    @(posedge clk);
    #1;
    chk("stall_hold", ex_to_mem_bus,
        {32'h40, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'd7});
    tb_stall = 6'b000111;
    @(posedge clk);
    #1;
    chk("stall_bubble_mem", ex_to_mem_bus, 76'h0);
    chk("stall_bubble_rf", ex_to_rf_bus, 38'h0);

    for (int i = 0; i < 40; i++) begin
      k    = int'($urandom_range(0, 12));
      i1   = int'($urandom_range(0, 2));
      i2   = int'($urandom_range(0, 3));
      pc   = $urandom;
      inst = $urandom;
      inst[31:26] = 6'($urandom_range(1, 63));
      x    = $urandom;
      y    = $urandom;
      en   = 1'($urandom);
      wen  = 4'($urandom);
      we   = 1'($urandom);
      sel  = 1'($urandom);
      wa   = 5'($urandom);
      opv  = (k < 12) ? (12'h800 >> k) : 12'h000;
      a = (i1 == 0) ? x : (i1 == 1) ? pc : {27'd0, inst[10:6]};
      b = (i2 == 0) ? y :
          (i2 == 1) ? {{16{inst[15]}}, inst[15:0]} :
          (i2 == 2) ? 32'd8 : {16'd0, inst[15:0]};
      res = ref_alu(k, a, b);
      load(mk(pc, inst, opv, 3'(1 << i1), 4'(1 << i2), en, wen, we,
              wa, sel, x, y));
      check_alu($sformatf("rnd%0d_op%0d", i, k), pc, en, wen, sel, we,
                wa, y, res);
    end

    x = $urandom;
    y = $urandom;
    load(mt(FN_MTHI, x));
    hi_m = x;
    chk("mthi_res", ex_to_rf_bus, 38'h0);
    load(mt(FN_MTLO, y));
    lo_m = y;
    load(mf(FN_MFHI, 5'd8));
    chk("mfhi", ex_to_rf_bus, {1'b1, 5'd8, hi_m});
    chk("mfhi_mem", ex_to_mem_bus, {32'h0, 8'h0, 1'b1, 5'd8, hi_m});
    load(mf(FN_MFLO, 5'd9));
    chk("mflo", ex_to_rf_bus, {1'b1, 5'd9, lo_m});

`ifdef EX_DIV_EN
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_div("divu_10_0", 1'b0, 32'd10, 32'd0);
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++)
      run_div($sformatf("div_rnd%0d", i), 1'($urandom), $urandom,
              (i == 5) ? 32'd0 : 32'($urandom >> $urandom_range(0, 30)));

    load(mk(32'h0, {6'h0, 5'd4, 5'd5, 10'h0, FN_DIVU}, 12'h0, 3'h0,
            4'h0, 1'b0, 4'h0, 1'b0, 5'h0, 1'b0, 32'd1000, 32'd7));
    id_bus = mf(FN_MFHI, 5'd11);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_run_stallreq", stallreq_for_ex, 1'b0);
    chk("rst_run_mem", ex_to_mem_bus, 76'h0);
    rst = 1'b0;
    hi_m = 32'h0;
    lo_m = 32'h0;
    load(mf(FN_MFHI, 5'd11));
    chk("rst_run_hi", ex_to_rf_bus, {1'b1, 5'd11, hi_m});
    load(mf(FN_MFLO, 5'd12));
    chk("rst_run_lo", ex_to_rf_bus, {1'b1, 5'd12, lo_m});
`else
    load(mk(32'h0, {6'h0, 5'd4, 5'd5, 10'h0, FN_DIV}, 12'h0, 3'h0,
            4'h0, 1'b0, 4'h0, 1'b0, 5'h0, 1'b0, 32'd100, 32'd7));
    chk("nodiv_stallreq", stallreq_for_ex, 1'b0);
    load(mf(FN_MFHI, 5'd13));
    chk("nodiv_hi", ex_to_rf_bus, {1'b1, 5'd13, hi_m});
    load(mf(FN_MFLO, 5'd14));
    chk("nodiv_lo", ex_to_rf_bus, {1'b1, 5'd14, lo_m});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
